// File: rtl/valrdy_rr_arbiter.sv
// valrdy_rr_arbiter: round-robin val/rdy arbiter with a registered output stage; VALRDY_RR_ARBITER_LOCK_EN adds packet locking via recv_last.
module valrdy_rr_arbiter #(
  parameter int NumReqs = 4,
  parameter int Width = 32,
  localparam int IdxW = $clog2(NumReqs)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NumReqs-1:0]       recv_val,
  output logic [NumReqs-1:0]       recv_rdy,
  input  logic [NumReqs*Width-1:0] recv_msg,
`ifdef VALRDY_RR_ARBITER_LOCK_EN
  input  logic [NumReqs-1:0]       recv_last,
`endif
  output logic                     send_val,
  input  logic                     send_rdy,
  output logic [Width-1:0]         send_msg,
  output logic [IdxW-1:0]          send_idx
);
  logic [IdxW-1:0] ptr, gnt, gnt_nxt;
  logic found, can_accept, xfer;
`ifdef VALRDY_RR_ARBITER_LOCK_EN
  logic locked;
  logic [IdxW-1:0] lock_idx;
`endif
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int k = 0; k < NumReqs; k++) begin
      if (!found && recv_val[(int'(ptr) + k) % NumReqs]) begin
        found = 1'b1;
        gnt = IdxW'((int'(ptr) + k) % NumReqs);
      end
    end
`ifdef VALRDY_RR_ARBITER_LOCK_EN
    if (locked) begin
      gnt = lock_idx;
      found = recv_val[lock_idx];
    end
`endif
  end
  assign can_accept = ~send_val | send_rdy;
  assign xfer = found & can_accept;
  assign recv_rdy = xfer ? NumReqs'(1) << gnt : '0;
  // explicit wrap so non-power-of-2 NumReqs cycles back to 0
  assign gnt_nxt = (gnt == IdxW'(NumReqs - 1)) ? '0 : gnt + 1'b1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      send_val <= 1'b0;
      send_msg <= '0;
      send_idx <= '0;
      ptr <= '0;
`ifdef VALRDY_RR_ARBITER_LOCK_EN
      locked <= 1'b0;
      lock_idx <= '0;
`endif
    end else if (xfer) begin
      send_val <= 1'b1;
      send_msg <= recv_msg[int'(gnt)*Width +: Width];
      send_idx <= gnt;
`ifdef VALRDY_RR_ARBITER_LOCK_EN
      locked <= ~recv_last[gnt];
      lock_idx <= gnt;
      if (recv_last[gnt]) ptr <= gnt_nxt;
`else
      ptr <= gnt_nxt;
`endif
    end else if (send_rdy) begin
      send_val <= 1'b0;
    end
  end
endmodule

// File: tb/tb_valrdy_rr_arbiter.sv
// tb_valrdy_rr_arbiter: directed plus random checks of valrdy_rr_arbiter against a behavioural model.
module tb_valrdy_rr_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] recv_val, recv_rdy;
  logic [N*W-1:0] recv_msg;
  logic send_val, send_rdy;
  logic [W-1:0] send_msg;
  logic [1:0] send_idx;
`ifdef VALRDY_RR_ARBITER_LOCK_EN
  logic [N-1:0] recv_last;
`endif
  int vectors = 0;
  int miscompares = 0;
  int mptr, mlock, mi;
  bit mv;
  logic [W-1:0] mm;

  always #5 clk = ~clk;

  valrdy_rr_arbiter #(.NumReqs(N), .Width(W)) dut (
    .clk(clk), .reset(reset),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
`ifdef VALRDY_RR_ARBITER_LOCK_EN
    .recv_last(recv_last),
`endif
    .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg), .send_idx(send_idx)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_gnt();
    int order[$];
    if (mlock >= 0) return recv_val[mlock] ? mlock : -1;
    for (int k = 0; k < N; k++) order.push_back((mptr + k) % N);
    foreach (order[q]) if (recv_val[order[q]]) return order[q];
    return -1;
  endfunction

  task automatic cyc();
    int g;
    bit ca;
    #1;
    g = model_gnt();
    ca = !mv || send_rdy;
    chk("recv_rdy", 64'(recv_rdy), (g >= 0 && ca) ? 64'(1) << g : 64'(0));
    @(posedge clk);
    if (g >= 0 && ca) begin
      mv = 1'b1;
      mm = recv_msg[g*W +: W];
      mi = g;
`ifdef VALRDY_RR_ARBITER_LOCK_EN
      if (recv_last[g]) begin mlock = -1; mptr = (g + 1) % N; end
      else mlock = g;
`else
      mptr = (g + 1) % N;
`endif
    end else if (mv && send_rdy) mv = 1'b0;
    #1;
    chk("send_val", 64'(send_val), 64'(mv));
    chk("send_msg", 64'(send_msg), 64'(mm));
    chk("send_idx", 64'(send_idx), 64'(mi));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    mptr = 0; mlock = -1; mv = 1'b0; mm = '0; mi = 0;
    chk("rst_send_val", 64'(send_val), 64'(0));
    chk("rst_send_msg", 64'(send_msg), 64'(0));
    chk("rst_send_idx", 64'(send_idx), 64'(0));
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    recv_val = '0;
    recv_msg = '0;
    send_rdy = 1'b1;
`ifdef VALRDY_RR_ARBITER_LOCK_EN
    recv_last = '1;
`endif
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 5; i++) cyc();
    recv_val = 4'b0100;
    recv_msg = {32'h0, 32'hA5, 32'h0, 32'h0};
    #1 chk("single_rdy", 64'(recv_rdy), 64'b0100);
    cyc();
    chk("single_msg", 64'(send_msg), 64'hA5);
    chk("single_idx", 64'(send_idx), 64'd2);
    recv_val = '1;
    recv_msg = {32'h13, 32'h12, 32'h11, 32'h10};
    cyc();
    chk("ptr_after_single", 64'(send_idx), 64'd3);
    do_reset();
    recv_val = '1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr_seq", 64'(send_idx), 64'(i % N));
    end
    do_reset();
    recv_val = 4'b1000;
    recv_msg = {32'h33, 32'h22, 32'h11, 32'h00};
    cyc();
    recv_val = '1;
    send_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_msg", 64'(send_msg), 64'h33);
      chk("stall_idx", 64'(send_idx), 64'd3);
    end
    send_rdy = 1'b1;
    cyc();
    chk("after_stall_idx", 64'(send_idx), 64'd0);
    chk("midstream_val", 64'(send_val), 64'd1);
    do_reset();
    cyc();
    chk("post_reset_idx", 64'(send_idx), 64'd0);
`ifdef VALRDY_RR_ARBITER_LOCK_EN
    do_reset();
    recv_val = 4'b0110;
    recv_msg = {32'h0, 32'h2, 32'h1, 32'h0};
    recv_last = 4'b0100;
    cyc();
    chk("lock_b0", 64'(send_idx), 64'd1);
    cyc();
    chk("lock_b1", 64'(send_idx), 64'd1);
    recv_last = 4'b0110;
    cyc();
    chk("lock_b2", 64'(send_idx), 64'd1);
    cyc();
    chk("lock_next", 64'(send_idx), 64'd2);
`endif
    for (int i = 0; i < 400; i++) begin
      if (i % 97 == 50) do_reset();
      recv_val = 4'($urandom);
      recv_msg = {$urandom, $urandom, $urandom, $urandom};
      send_rdy = ($urandom_range(0, 3) != 0);
`ifdef VALRDY_RR_ARBITER_LOCK_EN
      recv_last = 4'($urandom);
`endif
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/valrdy_rr_arbiter.md
Name: valrdy_rr_arbiter

Overview:
- Round-robin arbiter that shares one val/rdy output stream among NumReqs val/rdy requester streams.
- Sits in front of a single-consumer datapath block and sequences which requester's message it receives.
- One registered output stage: 1-cycle latency, full throughput of 1 msg/cycle.
- Each output message is tagged with the index of the requester that sent it.

Parameters:
- NumReqs, 4, number of requester streams; legal range 2..16.
- Width, 32, message width in bits.
- IdxW, $clog2(NumReqs), width of the requester index (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  reset; asynchronous, active-low.
- recv_val  input  NumReqs  per-requester valid.
- recv_rdy  output  NumReqs  per-requester ready; at most one bit high per cycle.
- recv_msg  input  NumReqs*Width  requester messages; requester i occupies bits [i*Width +: Width].
- send_val  output  1  output valid (registered).
- send_rdy  input  1  downstream ready.
- send_msg  output  Width  output message (registered).
- send_idx  output  IdxW  index of the requester that sent send_msg (registered).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values, applied immediately on reset low:
  - send_val=0, send_msg=0, send_idx=0.
  - Priority pointer ptr=0, so requester 0 has highest priority.
  - Lock state cleared (only exists with ARB_LOCK_EN).
- Output register state:
  - Empty when send_val=0.
  - Drains when send_val & send_rdy.
  - can_accept = ~send_val | send_rdy. This is combinational; bypassing an occupied register is forbidden.
- Grant (combinational):
  - gnt = first i with recv_val[i]=1, scanning cyclically from ptr: ptr, ptr+1, ..., NumReqs-1, 0, ..., ptr-1.
  - recv_rdy[i] = (i==gnt) & recv_val[i] & can_accept.
  - All recv_rdy are 0 when no recv_val is set or can_accept=0.
- Transfer, when recv_val[gnt] & recv_rdy[gnt] at the clock edge:
  - send_msg <= recv_msg[gnt]; send_idx <= gnt; send_val <= 1.
  - ptr <= gnt+1, wrapping from NumReqs-1 to 0. The pointer does not wrap on powers of two via truncation alone; it must wrap correctly for non-power-of-2 NumReqs.
- Drain with no transfer (send_val & send_rdy, no granted requester): send_val <= 0; send_msg and send_idx hold their values.
- Stall (send_val & ~send_rdy):
  - send_val, send_msg and send_idx are held stable.
  - ptr unchanged; all recv_rdy=0.
- Simultaneous drain and accept in the same cycle: the new message is loaded, send_val stays 1, and no bubble is inserted.
- No request: ptr unchanged.
- Fairness: a continuously-valid requester is granted within NumReqs transfers.
- Latency: a message accepted at edge k appears on send_* in the cycle after edge k.
- Reset asserted mid-transfer: the message in the output register is discarded and all state returns to reset values. Requesters must re-send.
- recv_val may drop without handshake; the arbiter holds no per-requester state other than ptr (and the lock).

Optional Feature:
- Macro: VALRDY_RR_ARBITER_LOCK_EN.
- Defined:
  - Adds port recv_last  input  NumReqs, which marks the last beat of a multi-beat packet.
  - After a transfer from gnt with recv_last[gnt]=0, a lock is set to gnt. While locked, only the locked requester can be granted, regardless of other valids.
  - A transfer with recv_last=1 clears the lock and advances ptr to gnt+1.
  - ptr is not advanced by non-last beats.
  - Reset clears the lock.
- Undefined: no recv_last port, and every beat is arbitrated independently as above.

Test Plan:
- Reset then idle: recv_val=0 for 5 cycles -> send_val=0, recv_rdy=0, send_msg=0 throughout.
- Single requester: NumReqs=4, recv_val=4'b0100, msg 0xA5, send_rdy=1 -> recv_rdy=4'b0100. Next cycle send_val=1, send_msg=0xA5, send_idx=2; ptr becomes 3.
- All valid, send_rdy=1 held, messages 0x10,0x11,0x12,0x13 -> send_idx sequence 0,1,2,3,0, one per cycle, no bubbles.
- Backpressure: output holds 0x33/idx 3, send_rdy=0 for 3 cycles with all recv_val=1 -> send_* stable and recv_rdy=0. When send_rdy rises, the next grant is idx 0.
- Reset mid-stream: assert reset low while send_val=1 -> send_val=0 before the next edge. After release with all valid, the first grant is idx 0.
- LOCK_EN: requester 1 sends 3 beats with recv_last=0,0,1 while requester 2 stays valid -> send_idx 1,1,1, then 2.
